// File: rtl/timekeeper_hms_if.sv
// rtl/timekeeper_hms_if.sv - time-load bus between a time source and the timekeeper
interface timekeeper_hms_if;
   logic       load;
   logic [4:0] load_h;
   logic [5:0] load_m;
   logic [5:0] load_s;
   logic       load_err;

   modport master (output load, load_h, load_m, load_s, input load_err);
   modport slave  (input load, load_h, load_m, load_s, output load_err);
endinterface

// File: rtl/timekeeper_hms.sv
// rtl/timekeeper_hms.sv - hh:mm:ss timekeeper with prescaler, adjust keys, load and 12/24 h display
module timekeeper_hms #(
   parameter int TICK_DIV = 50000000,
   parameter int ADJ_DIV  = 25000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   adj_min,
   input  logic                   adj_hr,
   input  logic                   mode12,
   timekeeper_hms_if.slave        ld,
   output logic [3:0]             h_tens,
   output logic [3:0]             h_ones,
   output logic [3:0]             m_tens,
   output logic [3:0]             m_ones,
   output logic [3:0]             s_tens,
   output logic [3:0]             s_ones,
   output logic                   pm,
   output logic                   tick,
   output logic                   hour_strobe
);
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (ADJ_DIV > 2) ? $clog2(ADJ_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] REP_MAX   = AW'(ADJ_DIV - 1);

   logic [4:0]    hour_q, hour_d;
   logic [5:0]    min_q, min_d, sec_q, sec_d;
   logic [PW-1:0] presc_q, presc_d, presc_run;
   logic [AW-1:0] rep_q, rep_d;
   logic          min_key_q, hr_key_q;
   logic          tick_q, hs_q, err_q;
   logic          tick_d, hs_d, err_d;

   logic          wrap, any_key, key_rise, rep_done, step, load_ok;
   logic          sec_wrap, min_wrap, hour_carry;
   logic [5:0]    sec_tick, min_tick, min_inc;
   logic [4:0]    hour_inc, disp_hour;

   // the tick wraps the prescaler; keys step on a fresh press or on repeat-counter expiry
   assign wrap     = enable && (presc_q == PRESC_MAX);
   assign any_key  = adj_min || adj_hr;
   assign key_rise = (adj_min && !min_key_q) || (adj_hr && !hr_key_q);
   assign rep_done = (rep_q == REP_MAX);
   assign step     = key_rise || (any_key && rep_done);
   assign load_ok  = (ld.load_h < 5'd24) && (ld.load_m < 6'd60) && (ld.load_s < 6'd60);

   assign sec_wrap   = (sec_q == 6'd59);
   assign min_wrap   = (min_q == 6'd59);
   assign hour_carry = sec_wrap && min_wrap;
   assign sec_tick   = sec_wrap ? 6'd0 : sec_q + 6'd1;
   assign min_inc    = min_wrap ? 6'd0 : min_q + 6'd1;
   assign min_tick   = sec_wrap ? min_inc : min_q;
   assign hour_inc   = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
   assign presc_run  = enable ? (wrap ? '0 : presc_q + PW'(1)) : presc_q;

   // next-state: priority load > adjust step > tick
   always_comb begin
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      presc_d = presc_run;
      rep_d   = rep_q;
      hs_d    = 1'b0;
      err_d   = 1'b0;

      if (key_rise || !any_key) begin
         rep_d = '0;
      end else begin
         rep_d = rep_done ? '0 : rep_q + AW'(1);
      end

      if (ld.load) begin
         if (load_ok) begin
            hour_d  = ld.load_h;
            min_d   = ld.load_m;
            sec_d   = ld.load_s;
            presc_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (step) begin
         // a minute step swallows any coincident tick; an hour step keeps the
         // tick's second/minute advance but drops its carry into the hour
         if (adj_min) begin
            min_d   = min_inc;
            sec_d   = 6'd0;
            presc_d = '0;
         end else if (wrap) begin
            sec_d = sec_tick;
            min_d = min_tick;
         end
         if (adj_hr) begin
            hour_d = hour_inc;
         end
      end else if (wrap) begin
         sec_d = sec_tick;
         min_d = min_tick;
         if (hour_carry) begin
            hour_d = hour_inc;
            hs_d   = 1'b1;
         end
      end

      tick_d = (presc_d == PRESC_MAX) && (presc_q != PRESC_MAX);
   end

   // state and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hour_q    <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         presc_q   <= '0;
         rep_q     <= '0;
         min_key_q <= 1'b0;
         hr_key_q  <= 1'b0;
         tick_q    <= 1'b0;
         hs_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         hour_q    <= hour_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         presc_q   <= presc_d;
         rep_q     <= rep_d;
         min_key_q <= adj_min;
         hr_key_q  <= adj_hr;
         tick_q    <= tick_d;
         hs_q      <= hs_d;
         err_q     <= err_d;
      end
   end

   assign tick        = tick_q;
   assign hour_strobe = hs_q;
   assign ld.load_err = err_q;

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] t;
      logic [5:0] r;
      t = 4'd0;
      r = v;
      for (int i = 0; i < 5; i++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      return {t, r[3:0]};
   endfunction

   // display hour: 0 shows as 12 and afternoon hours fold down in 12 h mode
   always_comb begin
      disp_hour = hour_q;
      if (mode12) begin
         if (hour_q == 5'd0) begin
            disp_hour = 5'd12;
         end else if (hour_q > 5'd12) begin
            disp_hour = hour_q - 5'd12;
         end
      end
   end

   assign {h_tens, h_ones} = to_bcd({1'b0, disp_hour});
   assign {m_tens, m_ones} = to_bcd(min_q);
   assign {s_tens, s_ones} = to_bcd(sec_q);
   assign pm = mode12 && (hour_q >= 5'd12);
endmodule

// File: tb/tb_timekeeper_hms.sv
// tb/tb_timekeeper_hms.sv - self-checking bench for timekeeper_hms
module tb_timekeeper_hms;
   localparam int TD = 4;
   localparam int AD = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic adj_min = 1'b0;
   logic adj_hr = 1'b0;
   logic mode12 = 1'b0;
   logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
   logic pm, tick, hour_strobe;
   logic [23:0] digits;

   timekeeper_hms_if ld();

   timekeeper_hms #(.TICK_DIV(TD), .ADJ_DIV(AD)) dut (
      .clk(clk), .rst(rst), .enable(enable), .adj_min(adj_min), .adj_hr(adj_hr),
      .mode12(mode12), .ld(ld),
      .h_tens(h_tens), .h_ones(h_ones), .m_tens(m_tens), .m_ones(m_ones),
      .s_tens(s_tens), .s_ones(s_ones), .pm(pm), .tick(tick), .hour_strobe(hour_strobe)
   );

   always #5 clk = ~clk;

   assign digits = {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones};

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;
   int hs_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // reference model: time as seconds-of-day, phase within the current second
   int  m_secs = 0;
   int  m_phase = 0;
   int  m_held = 0;
   bit  m_pmin = 0, m_phr = 0;
   bit  e_tick = 0, e_hs = 0, e_err = 0;
   bit  m_valid = 0;

   always @(posedge clk) begin : model
      int s, ph, held, t;
      bit wrap, any, rise, step, good, hs;
      if (rst) begin
         m_secs <= 0; m_phase <= 0; m_held <= 0; m_pmin <= 0; m_phr <= 0;
         e_tick <= 0; e_hs <= 0; e_err <= 0; m_valid <= 1;
      end else begin
         s = m_secs; ph = m_phase; held = m_held; hs = 0;
         wrap = enable && (ph == TD - 1);
         any  = adj_min || adj_hr;
         rise = (adj_min && !m_pmin) || (adj_hr && !m_phr);
         if (rise) held = 0;
         else if (any) held = held + 1;
         else held = 0;
         step = any && (held % AD == 0);
         if (enable) ph = (ph + 1) % TD;
         good = ld.load && (int'(ld.load_h) < 24) && (int'(ld.load_m) < 60) && (int'(ld.load_s) < 60);
         if (ld.load) begin
            if (good) begin
               s = int'(ld.load_h) * 3600 + int'(ld.load_m) * 60 + int'(ld.load_s);
               ph = 0;
            end
         end else if (step) begin
            if (adj_min) begin
               s = (s / 3600) * 3600 + (((s / 60) % 60 + 1) % 60) * 60;
               ph = 0;
            end else if (wrap) begin
               t = s + 1;
               if (t % 3600 == 0) t = t - 3600;
               s = t;
            end
            if (adj_hr) s = (s + 3600) % 86400;
         end else if (wrap) begin
            s = (s + 1) % 86400;
            hs = (s % 3600 == 0);
         end
         e_tick  <= (ph == TD - 1) && (m_phase != TD - 1);
         e_hs    <= hs;
         e_err   <= ld.load && !good;
         m_secs  <= s;
         m_phase <= ph;
         m_held  <= held;
         m_pmin  <= adj_min;
         m_phr   <= adj_hr;
      end
   end

   function automatic logic [24:0] view(input int secs, input bit m12);
      int h, dh, mi, sc;
      h = secs / 3600; mi = (secs / 60) % 60; sc = secs % 60; dh = h;
      if (m12) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
      return {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10), 4'(sc / 10), 4'(sc % 10),
              1'(m12 && h >= 12)};
   endfunction

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("cycle", {4'b0, digits, pm, tick, hour_strobe, ld.load_err},
               {4'b0, view(m_secs, mode12), e_tick, e_hs, e_err});
         if (tick === 1'b1) tick_cnt++;
         if (hour_strobe === 1'b1) hs_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int h, input int m, input int s);
      ld.load = 1'b1;
      ld.load_h = 5'(h);
      ld.load_m = 6'(m);
      ld.load_s = 6'(s);
      cyc(1);
      ld.load = 1'b0;
   endtask

   int base;

   initial begin
      ld.load = 1'b0; ld.load_h = '0; ld.load_m = '0; ld.load_s = '0;
      cyc(2);
      check("rst_digits", digits, 24'h000000);
      check("rst_pulses", {tick, hour_strobe, ld.load_err, pm}, 0);
      mode12 = 1'b1; #1;
      check("rst_digits_12h", digits, 24'h120000);
      check("rst_pm_12h", pm, 0);
      mode12 = 1'b0;
      rst = 1'b0;

      // 23:59:58 rolls to midnight after two ticks
      enable = 1'b1;
      do_load(23, 59, 58);
      base = hs_cnt;
      cyc(3);
      check("first_tick", tick, 1);
      cyc(1);
      check("roll_mid", digits, 24'h235959);
      cyc(4);
      check("roll_digits", digits, 24'h000000);
      cyc(1);
      check("roll_hs_once", hs_cnt - base, 1);
      enable = 1'b0;

      // rejected load then valid load in 12 h mode
      do_load(24, 0, 0);
      check("bad_load_err", ld.load_err, 1);
      check("bad_load_time", digits, 24'h000000);
      cyc(1);
      check("bad_load_err_single", ld.load_err, 0);
      mode12 = 1'b1;
      do_load(12, 0, 0);
      check("noon_12h", digits, 24'h120000);
      check("noon_pm", pm, 1);
      mode12 = 1'b0;

      // minute auto-repeat from 00:59:30
      enable = 1'b1;
      do_load(0, 59, 30);
      adj_min = 1'b1;
      cyc(1);
      check("min_step0", digits, 24'h000000);
      cyc(3);
      check("min_step3", digits, 24'h000100);
      cyc(3);
      check("min_step6", digits, 24'h000200);
      adj_min = 1'b0;
      cyc(1);

      // frozen time, single hour press
      enable = 1'b0;
      do_load(23, 10, 5);
      base = tick_cnt;
      cyc(20);
      check("frozen_time", digits, 24'h231005);
      check("frozen_no_tick", tick_cnt - base, 0);
      adj_hr = 1'b1;
      cyc(1);
      adj_hr = 1'b0;
      check("hr_wrap", digits, 24'h001005);
      cyc(5);
      check("hr_single", digits, 24'h001005);

      // minute key on the tick cycle at 00:00:59
      enable = 1'b1;
      do_load(0, 0, 59);
      cyc(3);
      check("align_tick", tick, 1);
      check("align_before", digits, 24'h000059);
      adj_min = 1'b1;
      cyc(1);
      adj_min = 1'b0;
      check("align_after", digits, 24'h000100);
      check("align_no_hs", hour_strobe, 0);
      cyc(3);
      check("align_hold", digits, 24'h000100);
      cyc(1);
      check("align_presc_restart", digits, 24'h000101);

      // hour key on the tick cycle at 05:59:59
      do_load(5, 59, 59);
      cyc(3);
      adj_hr = 1'b1;
      cyc(1);
      adj_hr = 1'b0;
      check("hr_tick_digits", digits, 24'h060000);
      check("hr_tick_no_hs", hour_strobe, 0);

      // both keys held
      enable = 1'b0;
      do_load(23, 59, 59);
      adj_min = 1'b1; adj_hr = 1'b1;
      cyc(1);
      check("both_step0", digits, 24'h000000);
      cyc(3);
      check("both_step3", digits, 24'h010100);
      adj_min = 1'b0; adj_hr = 1'b0;
      cyc(1);

      // 12 h fold of an afternoon hour
      do_load(13, 5, 0);
      mode12 = 1'b1; #1;
      check("pm_fold", digits, 24'h010500);
      check("pm_flag", pm, 1);
      mode12 = 1'b0;

      // reset during hour auto-repeat
      do_load(0, 0, 0);
      adj_hr = 1'b1;
      cyc(4);
      rst = 1'b1;
      cyc(1);
      check("rst_mid_repeat", digits, 24'h000000);
      rst = 1'b0;
      cyc(1);
      check("rst_new_press", digits, 24'h010000);
      adj_hr = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/timekeeper_hms.md
TIMEKEEPER_HMS -- requirements
Module: timekeeper_hms

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (>=2).
REQ-002 Parameter ADJ_DIV, default 25000000, clk cycles between auto-repeat adjust steps (>=2).
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 enable  in  1  run; 1 = prescaler counts, 0 = prescaler and time frozen, except adjust and load.
REQ-006 adj_min  in  1  minute-adjust key, level, held = auto-repeat.
REQ-007 adj_hr  in  1  hour-adjust key, level, held = auto-repeat.
REQ-008 mode12  in  1  display mode; 0 = 24 h, 1 = 12 h with pm flag.
REQ-009 load  in  1  one-cycle strobe; load_h/load_m/load_s sampled this cycle.
REQ-010 load_h  in  5  binary hour 0..23; load_m  in  6  binary minute 0..59; load_s  in  6  binary second 0..59.
REQ-011 h_tens, h_ones, m_tens, m_ones, s_tens, s_ones  out  4 each  BCD display digits.
REQ-012 pm  out  1  1 when mode12=1 and hour >= 12, else 0.
REQ-013 tick  out  1  one-cycle pulse per prescaler wrap.
REQ-014 hour_strobe  out  1  one-cycle pulse on tick-driven xx:59:59 -> (xx+1):00:00 rollover.
REQ-015 load_err  out  1  one-cycle pulse when load is rejected.

Function
REQ-016 Time SHALL be held internally as binary 24 h hour (0..23), minute (0..59), second (0..59); digits SHALL be decoded combinationally from these registers.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while enable=1, hold its value while enable=0, and assert tick in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-018 On tick: second+1; 59 -> 0 with carry to minute; minute 59 -> 0 with carry to hour; hour 23 -> 0; time updates on the same edge as the tick pulse ends.
REQ-019 Each adjust key SHALL be edge-detected: a step fires in the first cycle the key is seen high, then every ADJ_DIV cycles while held; a shared repeat counter restarts on a rising edge of either key.
REQ-020 Minute step: minute+1 mod 60, no carry into hour, second cleared to 0, prescaler cleared to 0.
REQ-021 Hour step: hour+1 mod 24, minute and second unaffected.
REQ-022 Both keys held: each step cycle applies both minute and hour steps.
REQ-023 Adjust SHALL operate regardless of enable.
REQ-024 Priority per cycle: rst > load > adjust step > tick.
REQ-025 Minute step coincident with tick: tick ignored (second = 0, no carry, no hour_strobe).
REQ-026 Hour step coincident with tick: second/minute advance normally; tick carry into hour dropped; hour_strobe suppressed.
REQ-027 load with all fields in range: time = loaded value next edge, prescaler cleared, repeat counter unaffected.
REQ-028 load with any field out of range: time unchanged, tick processing for that cycle suppressed, load_err pulses next cycle.
REQ-029 mode12=1: hour 0 shows 12, hours 1..12 shown as-is, 13..23 shown as hour-12; mode12 changes affect outputs immediately with no state change.
REQ-030 tick, hour_strobe and load_err SHALL be registered single-cycle pulses, never asserted two consecutive cycles.

Reset
REQ-031 rst=1 SHALL clear time to 00:00:00, prescaler, repeat counter, key edge detectors and all pulse outputs to 0.
REQ-032 After reset, digits SHALL read 0,0,0,0,0,0 with mode12=0, or 1,2,0,0,0,0 with mode12=1; pm=0.
REQ-033 A key held across reset release SHALL count as a new press (step on first cycle after rst deasserts).

Verification (TICK_DIV=4, ADJ_DIV=3)
REQ-034 Load 23:59:58, enable=1 -> after 2 ticks (8 cycles) digits 0,0,0,0,0,0; hour_strobe exactly once, with the second tick.
REQ-035 Load h=24 m=0 s=0 -> load_err one pulse, time unchanged; then load 12:00:00 with mode12=1 -> 1,2,0,0,0,0, pm=1.
REQ-036 From 00:59:30 hold adj_min 7 cycles -> steps at cycles 0,3,6 -> 00:02:00; hour unchanged.
REQ-037 enable=0 for 20 cycles at 23:10:05 -> no tick, time frozen; single adj_hr press -> 00:10:05.
REQ-038 Align adj_min rising edge with tick cycle at 00:00:59 -> 00:01:00, no hour_strobe, prescaler restarts at 0.
REQ-039 Assert rst mid auto-repeat with adj_hr held -> 00:00:00 next edge; first cycle after release steps hour to 01.
